traffic_phase_sched: RTL and testbench

TRAFFIC_PHASE_SCHED -- requirements
Module: traffic_phase_sched

---
 rtl/traffic_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 35 +++
 rtl/traffic_phase_sched.sv | 157 +++++++++++++++
 tb/tb_traffic_phase_sched.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared state encoding, per-approach lamp type and default timing
// for the traffic phase scheduler.
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_ALLRED = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2,
        ST_FLASH  = 2'd3
    } state_e;

    // Lamp set of one approach; exactly one bit is lit outside flash mode.
    typedef struct packed {
        logic grn;
        logic ylw;
        logic red;
    } lamp_t;

    localparam lamp_t LAMP_RED = '{grn: 1'b0, ylw: 1'b0, red: 1'b1};
    localparam lamp_t LAMP_YLW = '{grn: 1'b0, ylw: 1'b1, red: 1'b0};
    localparam lamp_t LAMP_GRN = '{grn: 1'b1, ylw: 1'b0, red: 1'b0};

    localparam int unsigned DEF_NUM_APP  = 4;
    localparam int unsigned DEF_PRESCALE = 16;
    localparam int unsigned DEF_T_GMIN   = 4;
    localparam int unsigned DEF_T_GMAX   = 12;
    localparam int unsigned DEF_T_YLW    = 3;
    localparam int unsigned DEF_T_AR     = 1;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the next requesting approach.
// Ports:
//   req      - per-approach demand
//   last_idx - most recently granted approach; search starts just after it
//   nxt_idx  - first requester after last_idx (wrapping; last_idx itself is last)
//   valid    - at least one request is present
module rr_arbiter
    import traffic_pkg::*;
#(
    parameter  int unsigned NUM_APP = DEF_NUM_APP,
    localparam int unsigned PW      = (NUM_APP > 1) ? $clog2(NUM_APP) : 1
) (
    input  logic [NUM_APP-1:0] req,
    input  logic [PW-1:0]      last_idx,
    output logic [PW-1:0]      nxt_idx,
    output logic               valid
);

    logic [PW-1:0] idx;

    // Walk offsets 1..NUM_APP from last_idx; first hit wins.
    always_comb begin
        nxt_idx = last_idx;
        valid   = 1'b0;
        idx     = last_idx;
        for (int unsigned i = 1; i <= NUM_APP; i++) begin
            idx = PW'((32'(last_idx) + i) % NUM_APP);
            if (!valid && req[idx]) begin
                nxt_idx = idx;
                valid   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_phase_sched.sv
// traffic_phase_sched: round-robin traffic signal phase scheduler with
// min-green, yellow, all-red clearance and flash mode.
// Ports:
//   clk   - clock, rising edge
//   CLR_N - asynchronous active-low reset
//   TEST  - 1 = prescaler bypassed, one tick per clock
//   FM    - flash-mode request (level)
//   req   - per-approach demand (level, sampled at decision ticks)
//   GRN/YLW/RED - registered lamp outputs per approach
//   phase - index of the current or last granted approach
module traffic_phase_sched
    import traffic_pkg::*;
#(
    parameter  int unsigned NUM_APP  = DEF_NUM_APP,
    parameter  int unsigned PRESCALE = DEF_PRESCALE,
    parameter  int unsigned T_GMIN   = DEF_T_GMIN,
    parameter  int unsigned T_GMAX   = DEF_T_GMAX,
    parameter  int unsigned T_YLW    = DEF_T_YLW,
    parameter  int unsigned T_AR     = DEF_T_AR,
    localparam int unsigned PW       = (NUM_APP > 1) ? $clog2(NUM_APP) : 1
) (
    input  logic               clk,
    input  logic               CLR_N,
    input  logic               TEST,
    input  logic               FM,
    input  logic [NUM_APP-1:0] req,
    output logic [NUM_APP-1:0] GRN,
    output logic [NUM_APP-1:0] YLW,
    output logic [NUM_APP-1:0] RED,
    output logic [PW-1:0]      phase
);

    localparam int unsigned TW  = $clog2(T_GMAX + 1);
    localparam int unsigned PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    state_e             state, state_nxt;
    logic [TW-1:0]      timer, timer_inc, timer_nxt;
    logic [PSW-1:0]     pre;
    logic               tick;
    logic [PW-1:0]      phase_nxt, arb_idx;
    logic               arb_valid;
    logic [NUM_APP-1:0] grant_cur, grant_nxt;
    logic [NUM_APP-1:0] grn_nxt, ylw_nxt, red_nxt;
    lamp_t              act, rest;
    logic               flash_ylw;

    // Prescaler: free-running 0..PRESCALE-1, parked at 0 in test mode.
    always_ff @(posedge clk or negedge CLR_N) begin
        if (!CLR_N) begin
            pre <= '0;
        end else if (TEST || (pre == PSW'(PRESCALE - 1))) begin
            pre <= '0;
        end else begin
            pre <= pre + PSW'(1);
        end
    end

    assign tick = TEST | (pre == PSW'(PRESCALE - 1));

    // Tick count including the current tick, saturating at T_GMAX.
    assign timer_inc = (timer == TW'(T_GMAX)) ? timer : timer + TW'(1);

    assign grant_cur = NUM_APP'(1) << phase;
    assign grant_nxt = NUM_APP'(1) << phase_nxt;

    rr_arbiter #(
        .NUM_APP (NUM_APP)
    ) u_arb (
        .req      (req),
        .last_idx (phase),
        .nxt_idx  (arb_idx),
        .valid    (arb_valid)
    );

    // Next state, phase and timer; decisions are taken on ticks except the
    // flash-forced end of green, which does not wait for one.
    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        timer_nxt = timer;
        case (state)
            ST_ALLRED: begin
                if (tick && (timer_inc >= TW'(T_AR))) begin
                    if (FM) begin
                        state_nxt = ST_FLASH;
                    end else if (arb_valid) begin
                        state_nxt = ST_GREEN;
                        phase_nxt = arb_idx;
                    end
                end
            end
            ST_GREEN: begin
                if (FM) begin
                    state_nxt = ST_YELLOW;
                end else if (tick && (timer_inc >= TW'(T_GMIN)) && |(req & ~grant_cur)) begin
                    state_nxt = ST_YELLOW;
                end
            end
            ST_YELLOW: begin
                if (tick && (timer_inc >= TW'(T_YLW))) begin
                    state_nxt = ST_ALLRED;
                end
            end
            ST_FLASH: begin
                if (tick && !FM) begin
                    state_nxt = ST_ALLRED;
                end
            end
            default: state_nxt = ST_ALLRED;
        endcase
        if (state_nxt != state) begin
            timer_nxt = '0;
        end else if (tick) begin
            timer_nxt = timer_inc;
        end
    end

    // Lamp pattern for the state being entered: the granted approach gets
    // 'act', every other approach gets 'rest'.
    always_comb begin
        flash_ylw = (state == ST_FLASH) ? (YLW[0] ^ tick) : 1'b1;
        act       = LAMP_RED;
        rest      = LAMP_RED;
        case (state_nxt)
            ST_GREEN:  act = LAMP_GRN;
            ST_YELLOW: act = LAMP_YLW;
            ST_FLASH: begin
                act  = '{grn: 1'b0, ylw: flash_ylw, red: 1'b0};
                rest = act;
            end
            default: ;
        endcase
        grn_nxt = ({NUM_APP{act.grn}} & grant_nxt) | ({NUM_APP{rest.grn}} & ~grant_nxt);
        ylw_nxt = ({NUM_APP{act.ylw}} & grant_nxt) | ({NUM_APP{rest.ylw}} & ~grant_nxt);
        red_nxt = ({NUM_APP{act.red}} & grant_nxt) | ({NUM_APP{rest.red}} & ~grant_nxt);
    end

    // State, timer, phase and lamps update on the same edge.
    always_ff @(posedge clk or negedge CLR_N) begin
        if (!CLR_N) begin
            state <= ST_ALLRED;
            timer <= '0;
            phase <= PW'(NUM_APP - 1);
            GRN   <= '0;
            YLW   <= '0;
            RED   <= '1;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            phase <= phase_nxt;
            GRN   <= grn_nxt;
            YLW   <= ylw_nxt;
            RED   <= red_nxt;
        end
    end

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Self-checking bench for traffic_phase_sched using an expected-output queue.
module tb_traffic_phase_sched;

    logic       clk = 1'b0;
    logic       CLR_N;
    logic       TEST;
    logic       FM;
    logic [3:0] req;
    logic [3:0] GRN, YLW, RED;
    logic [1:0] phase;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] grn;
        logic [3:0] ylw;
        logic [3:0] red;
        logic [1:0] ph;
    } exp_t;

    typedef enum {K_AR, K_G, K_Y, K_F1, K_F0} kind_e;

    exp_t sb[$];

    traffic_phase_sched #(
        .NUM_APP  (4),
        .PRESCALE (16),
        .T_GMIN   (4),
        .T_GMAX   (12),
        .T_YLW    (3),
        .T_AR     (1)
    ) dut (
        .clk   (clk),
        .CLR_N (CLR_N),
        .TEST  (TEST),
        .FM    (FM),
        .req   (req),
        .GRN   (GRN),
        .YLW   (YLW),
        .RED   (RED),
        .phase (phase)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input kind_e k, input logic [1:0] ph, input int n);
        exp_t       e;
        logic [3:0] oh;
        oh    = 4'b0001 << ph;
        e.ph  = ph;
        e.grn = 4'b0000;
        e.ylw = 4'b0000;
        e.red = 4'b1111;
        case (k)
            K_G:  begin e.grn = oh; e.red = ~oh; end
            K_Y:  begin e.ylw = oh; e.red = ~oh; end
            K_F1: begin e.ylw = 4'b1111; e.red = 4'b0000; end
            K_F0: begin e.red = 4'b0000; end
            default: ;
        endcase
        repeat (n) sb.push_back(e);
    endtask

    // One full service of approach ph: 4 green, 3 yellow, 1 all-red.
    task automatic push_service(input logic [1:0] ph);
        push_exp(K_G, ph, 4);
        push_exp(K_Y, ph, 3);
        push_exp(K_AR, ph, 1);
    endtask

    task automatic apply_reset(input logic t, input logic f, input logic [3:0] r);
        step();
        CLR_N = 1'b0;
        TEST  = t;
        FM    = f;
        req   = r;
        step();
        step();
        CLR_N = 1'b1;
        sb.delete();
    endtask

    task automatic test_reset();
        CLR_N = 1'b0;
        TEST  = 1'b1;
        FM    = 1'b0;
        req   = 4'b0000;
        step();
        step();
        checks++;
        if ({GRN, YLW, RED, phase} !== {4'b0000, 4'b0000, 4'b1111, 2'd3}) begin
            failures++;
            $display("FAIL reset: grn=%b ylw=%b red=%b ph=%0d, want 0000 0000 1111 3", GRN, YLW, RED, phase);
        end
        // no demand: stays all-red
        CLR_N = 1'b1;
        push_exp(K_AR, 2'd3, 6);
        while (sb.size() != 0) begin
            exp_t e;
            step();
            e = sb.pop_front();
            checks++;
            if ({GRN, YLW, RED, phase} !== {e.grn, e.ylw, e.red, e.ph}) begin
                failures++;
                $display("FAIL idle t=%0t got %b %b %b %0d want %b %b %b %0d", $time, GRN, YLW, RED, phase, e.grn, e.ylw, e.red, e.ph);
            end
        end
    endtask

    // Single demand: grant after one tick, green held; short pulse ignored.
    task automatic test_single();
        apply_reset(1'b1, 1'b0, 4'b0001);
        push_exp(K_G, 2'd0, 1);
        for (int seg = 0; seg < 3; seg++) begin
            if (seg == 1) begin
                req = 4'b0011;
                push_exp(K_G, 2'd0, 1);
            end else if (seg == 2) begin
                req = 4'b0001;
                push_exp(K_G, 2'd0, 20);
            end
            while (sb.size() != 0) begin
                exp_t e;
                step();
                e = sb.pop_front();
                checks++;
                if ({GRN, YLW, RED, phase} !== {e.grn, e.ylw, e.red, e.ph}) begin
                    failures++;
                    $display("FAIL single t=%0t got %b %b %b %0d want %b %b %b %0d", $time, GRN, YLW, RED, phase, e.grn, e.ylw, e.red, e.ph);
                end
            end
        end
    endtask

    task automatic test_alternate();
        apply_reset(1'b1, 1'b0, 4'b0011);
        push_service(2'd0);
        push_service(2'd1);
        push_exp(K_G, 2'd0, 4);
        while (sb.size() != 0) begin
            exp_t e;
            step();
            e = sb.pop_front();
            checks++;
            if ({GRN, YLW, RED, phase} !== {e.grn, e.ylw, e.red, e.ph}) begin
                failures++;
                $display("FAIL alternate t=%0t got %b %b %b %0d want %b %b %b %0d", $time, GRN, YLW, RED, phase, e.grn, e.ylw, e.red, e.ph);
            end
        end
    endtask

    task automatic test_rotate();
        apply_reset(1'b1, 1'b0, 4'b1111);
        for (int p = 0; p < 4; p++) push_service(2'(p));
        push_exp(K_G, 2'd0, 4);
        while (sb.size() != 0) begin
            exp_t e;
            step();
            e = sb.pop_front();
            checks++;
            if ({GRN, YLW, RED, phase} !== {e.grn, e.ylw, e.red, e.ph}) begin
                failures++;
                $display("FAIL rotate t=%0t got %b %b %b %0d want %b %b %b %0d", $time, GRN, YLW, RED, phase, e.grn, e.ylw, e.red, e.ph);
            end
        end
    endtask

    // Only the current phase still requesting at all-red: same approach again.
    task automatic test_regrant();
        apply_reset(1'b1, 1'b0, 4'b0011);
        push_exp(K_G, 2'd0, 4);
        push_exp(K_Y, 2'd0, 1);
        for (int seg = 0; seg < 2; seg++) begin
            if (seg == 1) begin
                req = 4'b0001;
                push_exp(K_Y, 2'd0, 2);
                push_exp(K_AR, 2'd0, 1);
                push_exp(K_G, 2'd0, 3);
            end
            while (sb.size() != 0) begin
                exp_t e;
                step();
                e = sb.pop_front();
                checks++;
                if ({GRN, YLW, RED, phase} !== {e.grn, e.ylw, e.red, e.ph}) begin
                    failures++;
                    $display("FAIL regrant t=%0t got %b %b %b %0d want %b %b %b %0d", $time, GRN, YLW, RED, phase, e.grn, e.ylw, e.red, e.ph);
                end
            end
        end
    endtask

    task automatic test_flash();
        apply_reset(1'b1, 1'b0, 4'b0001);
        push_exp(K_G, 2'd0, 3);
        for (int seg = 0; seg < 3; seg++) begin
            if (seg == 1) begin
                FM = 1'b1;
                push_exp(K_Y, 2'd0, 3);
                push_exp(K_AR, 2'd0, 1);
                for (int k = 0; k < 3; k++) begin
                    push_exp(K_F1, 2'd0, 1);
                    push_exp(K_F0, 2'd0, 1);
                end
            end else if (seg == 2) begin
                FM  = 1'b0;
                req = 4'b0011;
                push_exp(K_AR, 2'd0, 1);
                push_exp(K_G, 2'd1, 4);
            end
            while (sb.size() != 0) begin
                exp_t e;
                step();
                e = sb.pop_front();
                checks++;
                if ({GRN, YLW, RED, phase} !== {e.grn, e.ylw, e.red, e.ph}) begin
                    failures++;
                    $display("FAIL flash t=%0t got %b %b %b %0d want %b %b %b %0d", $time, GRN, YLW, RED, phase, e.grn, e.ylw, e.red, e.ph);
                end
            end
        end
    endtask

    // Prescaled timing: one tick per 16 clocks, 64-clock minimum green.
    task automatic test_prescale();
        apply_reset(1'b0, 1'b0, 4'b0011);
        push_exp(K_AR, 2'd3, 15);
        push_exp(K_G, 2'd0, 64);
        push_exp(K_Y, 2'd0, 48);
        push_exp(K_AR, 2'd0, 16);
        push_exp(K_G, 2'd1, 4);
        while (sb.size() != 0) begin
            exp_t e;
            step();
            e = sb.pop_front();
            checks++;
            if ({GRN, YLW, RED, phase} !== {e.grn, e.ylw, e.red, e.ph}) begin
                failures++;
                $display("FAIL prescale t=%0t got %b %b %b %0d want %b %b %b %0d", $time, GRN, YLW, RED, phase, e.grn, e.ylw, e.red, e.ph);
            end
        end
    endtask

    task automatic test_reset_mid_yellow();
        apply_reset(1'b1, 1'b0, 4'b0011);
        push_exp(K_G, 2'd0, 4);
        push_exp(K_Y, 2'd0, 1);
        for (int seg = 0; seg < 2; seg++) begin
            if (seg == 1) begin
                CLR_N = 1'b0;
                #1;
                checks++;
                if ({GRN, YLW, RED, phase} !== {4'b0000, 4'b0000, 4'b1111, 2'd3}) begin
                    failures++;
                    $display("FAIL async_reset: got %b %b %b %0d want 0000 0000 1111 3", GRN, YLW, RED, phase);
                end
                step();
                step();
                checks++;
                if ({GRN, YLW, RED, phase} !== {4'b0000, 4'b0000, 4'b1111, 2'd3}) begin
                    failures++;
                    $display("FAIL reset_hold: got %b %b %b %0d want 0000 0000 1111 3", GRN, YLW, RED, phase);
                end
                CLR_N = 1'b1;
                push_exp(K_G, 2'd0, 2);
            end
            while (sb.size() != 0) begin
                exp_t e;
                step();
                e = sb.pop_front();
                checks++;
                if ({GRN, YLW, RED, phase} !== {e.grn, e.ylw, e.red, e.ph}) begin
                    failures++;
                    $display("FAIL reset_yellow t=%0t got %b %b %b %0d want %b %b %b %0d", $time, GRN, YLW, RED, phase, e.grn, e.ylw, e.red, e.ph);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_rotate();
        test_regrant();
        test_flash();
        test_prescale();
        test_reset_mid_yellow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
